ntt_addr_sched: RTL

Parametrised butterfly-schedule generator for the NTT/INTT datapath, replacing the fixed 512-point, two-lane sequencing in the current controller. Each accepted cycle it emits `LANES` butterfly address pairs, one shared-stage twiddle address per lane and stage/last flags over a valid/ready handshake. It sits between the start/mode control and the address-mapping, data-memory and twiddle-ROM stage that feeds the butterfly units.

---
 rtl/ntt_pkg.sv | 27 ++
 rtl/ntt_bf_addr.sv | 44 ++++
 rtl/ntt_addr_sched.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT butterfly-schedule generator.
//   state_t  : scheduler FSM states
//   clog2    : ceiling log2 for elaboration-time widths
//   tw_base  : twiddle-ROM base offset of the inverse (op = 1) table
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // The op bit sits directly above the LOGN-bit zeta index, so the inverse
  // table starts at 2^LOGN.
  function automatic int tw_base(input int logn);
    return 1 << logn;
  endfunction

endpackage

// File: rtl/ntt_bf_addr.sv
// Combinational address calculator for one butterfly.
//   i_op    : 0 forward, 1 inverse (selects twiddle table)
//   i_s     : stage number
//   i_bf    : butterfly index within the stage
//   o_addr0 : upper-leg data address
//   o_addr1 : lower-leg data address (o_addr0 + len)
//   o_tw    : twiddle address {op, 2^s + group}
module ntt_bf_addr
  import ntt_pkg::*;
#(
  parameter int LOGN = 9,
  parameter int SW   = 4
) (
  input  logic            i_op,
  input  logic [SW-1:0]   i_s,
  input  logic [LOGN-1:0] i_bf,
  output logic [LOGN-1:0] o_addr0,
  output logic [LOGN-1:0] o_addr1,
  output logic [LOGN:0]   o_tw
);

  localparam logic [LOGN:0]   TW_BASE = (LOGN+1)'(tw_base(LOGN));
  localparam logic [SW-1:0]   S_MAX   = SW'(LOGN - 1);
  localparam logic [LOGN-1:0] ONE     = LOGN'(1);

  logic [SW-1:0]   w_sh;
  logic [LOGN-1:0] w_len;
  logic [LOGN-1:0] w_g;
  logic [LOGN-1:0] w_j;
  logic [LOGN-1:0] w_idx;

  always_comb begin
    w_sh    = S_MAX - i_s;
    w_len   = ONE << w_sh;
    w_g     = i_bf >> w_sh;
    w_j     = i_bf & (w_len - ONE);
    // 2*g*len written as two shifts so the shift amount never needs LOGN+1 in SW bits
    o_addr0 = ((w_g << 1) << w_sh) | w_j;
    o_addr1 = o_addr0 + w_len;
    w_idx   = (ONE << i_s) + w_g;
    o_tw    = (i_op ? TW_BASE : '0) + {1'b0, w_idx};
  end

endmodule

// File: rtl/ntt_addr_sched.sv
// Butterfly-schedule generator for the NTT/INTT datapath. Emits LANES
// butterfly address pairs plus twiddle addresses per accepted beat, stage by
// stage, with STAGE_GAP bubble cycles between stages. All outputs registered.
//   clk, rst        : clock, synchronous active-high reset
//   start, op       : transform request and mode (0 NTT, 1 INTT), sampled in IDLE
//   busy, done      : transform in progress / one-cycle completion pulse
//   out_valid/ready : beat handshake
//   addr0, addr1    : per-lane leg addresses, lane L at [L*LOGN +: LOGN]
//   tw_addr         : per-lane twiddle address, lane L at [L*(LOGN+1) +: LOGN+1]
//   stage, last     : current stage, final beat of transform
//   op_q            : latched mode
//
// state | meaning
// IDLE  | waiting for start
// RUN   | presenting beats of the current stage
// GAP   | bubble between stages for BFU write-back
// DONE  | one-cycle done pulse
module ntt_addr_sched
  import ntt_pkg::*;
#(
  parameter  int LOGN      = 9,
  parameter  int LANES     = 2,
  parameter  int STAGE_GAP = 6,
  localparam int SW        = clog2(LOGN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op,
  output logic                      busy,
  output logic                      done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LOGN-1:0]     addr0,
  output logic [LANES*LOGN-1:0]     addr1,
  output logic [LANES*(LOGN+1)-1:0] tw_addr,
  output logic [SW-1:0]             stage,
  output logic                      last,
  output logic                      op_q
);

  localparam int            GW       = (STAGE_GAP > 1) ? clog2(STAGE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
  localparam logic [LOGN:0] HALF     = (LOGN+1)'(1 << (LOGN - 1));
  localparam logic [LOGN:0] LANES_W  = (LOGN+1)'(LANES);
  localparam logic [SW-1:0] S_LAST   = SW'(LOGN - 1);

  state_t                      r_state;
  logic [SW-1:0]               r_s;
  logic [LOGN-1:0]             r_b;
  logic [GW-1:0]               r_gap;
  logic                        r_op;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_valid;
  logic                        r_last;
  logic [LANES*LOGN-1:0]       r_addr0;
  logic [LANES*LOGN-1:0]       r_addr1;
  logic [LANES*(LOGN+1)-1:0]   r_tw;

  logic                        w_acc;
  logic [LOGN:0]               w_b_inc;
  logic                        w_stage_end;
  logic                        w_final;
  logic [SW-1:0]               w_s_adv;
  logic                        w_load;
  logic [SW-1:0]               w_s_nxt;
  logic [LOGN-1:0]             w_b_nxt;
  logic                        w_op_nxt;
  logic                        w_last_nxt;
  logic [LANES*LOGN-1:0]       w_addr0;
  logic [LANES*LOGN-1:0]       w_addr1;
  logic [LANES*(LOGN+1)-1:0]   w_tw;

  always_comb begin
    w_acc       = r_valid & out_ready;
    w_b_inc     = {1'b0, r_b} + LANES_W;
    w_stage_end = (w_b_inc == HALF);
    w_final     = r_op ? (r_s == '0) : (r_s == S_LAST);
    w_s_adv     = r_op ? (r_s - SW'(1)) : (r_s + SW'(1));
  end

  // Counter values of the beat to present next; addresses are computed from
  // these so the output registers load a complete beat in one edge.
  always_comb begin
    w_load   = 1'b0;
    w_s_nxt  = r_s;
    w_b_nxt  = r_b;
    w_op_nxt = r_op;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load   = 1'b1;
          w_op_nxt = op;
          w_s_nxt  = op ? S_LAST : '0;
          w_b_nxt  = '0;
        end
      end
      ST_RUN: begin
        if (w_acc && !w_stage_end) begin
          w_load  = 1'b1;
          w_b_nxt = w_b_inc[LOGN-1:0];
        end else if (w_acc && !w_final && (STAGE_GAP == 0)) begin
          w_load  = 1'b1;
          w_s_nxt = w_s_adv;
          w_b_nxt = '0;
        end
      end
      ST_GAP: begin
        if (r_gap == '0) begin
          w_load  = 1'b1;
          w_s_nxt = w_s_adv;
          w_b_nxt = '0;
        end
      end
      default: ;
    endcase
    w_last_nxt = (w_op_nxt ? (w_s_nxt == '0) : (w_s_nxt == S_LAST)) &&
                 (({1'b0, w_b_nxt} + LANES_W) == HALF);
  end

  for (genvar L = 0; L < LANES; L++) begin : g_lane
    logic [LOGN-1:0] w_bf;
    assign w_bf = w_b_nxt + LOGN'(L);
    ntt_bf_addr #(.LOGN(LOGN), .SW(SW)) u_bf_addr (
      .i_op    (w_op_nxt),
      .i_s     (w_s_nxt),
      .i_bf    (w_bf),
      .o_addr0 (w_addr0[L*LOGN +: LOGN]),
      .o_addr1 (w_addr1[L*LOGN +: LOGN]),
      .o_tw    (w_tw[L*(LOGN+1) +: LOGN+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_b     <= '0;
      r_gap   <= '0;
      r_op    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_addr0 <= '0;
      r_addr1 <= '0;
      r_tw    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_valid <= 1'b1;
        r_s     <= w_s_nxt;
        r_b     <= w_b_nxt;
        r_op    <= w_op_nxt;
        r_addr0 <= w_addr0;
        r_addr1 <= w_addr1;
        r_tw    <= w_tw;
        r_last  <= w_last_nxt;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_acc && w_stage_end) begin
            if (w_final) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (STAGE_GAP != 0) begin
              r_state <= ST_GAP;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_gap   <= GAP_LOAD;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == '0) r_state <= ST_RUN;
          else             r_gap   <= r_gap - GW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign addr0     = r_addr0;
  assign addr1     = r_addr1;
  assign tw_addr   = r_tw;
  assign stage     = r_s;
  assign last      = r_last;
  assign op_q      = r_op;

endmodule
